// File: rtl/fir_accumulator.sv
// +-----------------------------------------------------------------------------+
// | fir_accumulator: sums NUM_TAPS signed products, rounds, scales, narrows.   |
// | Optional macro FIR_ACC_SATURATE_EN clamps the result instead of wrapping.  |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fir_accumulator #(
  parameter int WORD_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 8,
  parameter int FRAC_BITS   = 15,
  parameter int ACC_WIDTH   = WORD_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [WORD_WIDTH+COEFF_WIDTH-1:0]             in_product,
  output logic [(NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1)-1:0] tap_idx,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [WORD_WIDTH-1:0]                  out_data
);

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [TAP_W-1:0] c_last_tap = TAP_W'(NUM_TAPS - 1);
  localparam logic signed [ACC_WIDTH:0] c_round =
    (FRAC_BITS > 0) ? ((ACC_WIDTH+1)'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0))
                    : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                       r_state;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [TAP_W-1:0]             r_tap_idx;
  logic                         r_out_valid;
  logic signed [WORD_WIDTH-1:0] r_out_data;

  logic                         w_accept;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic signed [ACC_WIDTH:0]    w_rounded;
  logic signed [ACC_WIDTH:0]    w_y;
  logic signed [WORD_WIDTH-1:0] w_scaled;

  assign in_ready  = (r_state != S_HOLD);
  assign tap_idx   = r_tap_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_accept   = in_valid && in_ready;
  assign w_prod_ext = ACC_WIDTH'($signed(in_product));
  // r_acc is zero in IDLE, so one adder serves both the first and later taps.
  assign w_sum      = r_acc + w_prod_ext;
  assign w_rounded  = {w_sum[ACC_WIDTH-1], w_sum} + c_round;
  assign w_y        = w_rounded >>> FRAC_BITS;

`ifdef FIR_ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH:0] c_max =
    {{(ACC_WIDTH + 2 - WORD_WIDTH){1'b0}}, {(WORD_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] c_min =
    {{(ACC_WIDTH + 2 - WORD_WIDTH){1'b1}}, {(WORD_WIDTH - 1){1'b0}}};

  always_comb begin
    w_scaled = w_y[WORD_WIDTH-1:0];
    if (w_y > c_max)
      w_scaled = c_max[WORD_WIDTH-1:0];
    else if (w_y < c_min)
      w_scaled = c_min[WORD_WIDTH-1:0];
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_y[ACC_WIDTH:WORD_WIDTH];
  assign w_scaled    = w_y[WORD_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_tap_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc <= w_sum;
            if (NUM_TAPS == 1) begin
              r_state     <= S_HOLD;
              r_out_data  <= w_scaled;
              r_out_valid <= 1'b1;
            end else begin
              r_state   <= S_ACCUM;
              r_tap_idx <= TAP_W'(1);
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum;
            if (r_tap_idx == c_last_tap) begin
              r_state     <= S_HOLD;
              r_out_data  <= w_scaled;
              r_out_valid <= 1'b1;
            end else begin
              r_tap_idx <= r_tap_idx + TAP_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_tap_idx   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_accumulator.sv
// +-----------------------------------------------------------------------------+
// | tb_fir_accumulator: directed bench for fir_accumulator with NUM_TAPS=4.     |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_fir_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_product = '0;
  logic [1:0]  tap_idx;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;

  int vectors = 0;
  int errors  = 0;

  fir_accumulator #(
    .WORD_WIDTH (16),
    .COEFF_WIDTH(16),
    .NUM_TAPS   (4),
    .FRAC_BITS  (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .tap_idx   (tap_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] p);
    in_valid   = 1'b1;
    in_product = p;
    step();
    in_valid   = 1'b0;
    in_product = '0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic frame(input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] p2, input logic [31:0] p3);
    send(p0);
    send(p1);
    send(p2);
    send(p3);
  endtask

  logic [15:0] held;

  initial begin
    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'b0, out_data},  32'd0);
    chk("rst_tap_idx",   {30'b0, tap_idx},   32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

    // 1. Zero frame, tap_idx progression and latency
    send(32'd0);
    chk("t1_tap1", {30'b0, tap_idx}, 32'd1);
    send(32'd0);
    chk("t1_tap2", {30'b0, tap_idx}, 32'd2);
    send(32'd0);
    chk("t1_tap3", {30'b0, tap_idx}, 32'd3);
    chk("t1_valid_early", {31'b0, out_valid}, 32'd0);
    send(32'd0);
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_data",  {16'b0, out_data},  32'd0);
    chk("t1_hold_ready", {31'b0, in_ready}, 32'd0);
    drain();
    chk("t1_drain_valid", {31'b0, out_valid}, 32'd0);
    chk("t1_drain_tap",   {30'b0, tap_idx},   32'd0);
    chk("t1_drain_ready", {31'b0, in_ready},  32'd1);

    // 2. Round half up
    frame(32'd16384, 32'd0, 32'd0, 32'd0);
    chk("t2_pos_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_pos_data",  {16'b0, out_data},  32'd1);
    drain();
    frame(-32'sd16384, 32'd0, 32'd0, 32'd0);
    chk("t2_neg_data",  {16'b0, out_data},  32'd0);
    drain();

    // 3. Positive overflow: y = 32768
    frame(32'd268435456, 32'd268435456, 32'd268435456, 32'd268435456);
`ifdef FIR_ACC_SATURATE_EN
    chk("t3_pos_ovf", {16'b0, out_data}, 32'h7FFF);
`else
    chk("t3_pos_ovf", {16'b0, out_data}, 32'h8000);
`endif
    drain();

    // 4. Negative full scale: y = -32768 in both configurations
    frame(-32'sd268435456, -32'sd268435456, -32'sd268435456, -32'sd268435456);
    chk("t4_neg_fs", {16'b0, out_data}, 32'h8000);
    drain();

    // 5. Backpressure with products offered during HOLD
    frame(32'd65536, 32'd0, 32'd0, 32'd0);
    held = out_data;
    chk("t5_first", {16'b0, out_data}, 32'd2);
    in_valid   = 1'b1;
    in_product = 32'd1048576;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t5_hold_ready", {31'b0, in_ready},  32'd0);
      chk("t5_hold_data",  {16'b0, out_data},  {16'b0, held});
    end
    in_valid   = 1'b0;
    in_product = '0;
    drain();
    chk("t5_release_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_release_tap",   {30'b0, tap_idx},   32'd0);
    // 98304 + 16384 rounds to 3; an absorbed 2^20 would push it to 35
    frame(32'd98304, 32'd0, 32'd0, 32'd0);
    chk("t5_next_data", {16'b0, out_data}, 32'd3);
    drain();

    // 6. Reset mid-frame, then a frame with bubbles
    send(32'd1048576);
    send(32'd1048576);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_tap",   {30'b0, tap_idx},   32'd0);
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_ready", {31'b0, in_ready},  32'd1);
    send(32'd32768);
    step();
    send(32'd32768);
    step();
    step();
    send(32'd32768);
    step();
    chk("t6_bubble_tap",   {30'b0, tap_idx},   32'd3);
    chk("t6_bubble_valid", {31'b0, out_valid}, 32'd0);
    send(32'd32768);
    chk("t6_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_data",  {16'b0, out_data},  32'd4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
